// File: rtl/wb_sram_bridge_64x512_pkg.sv
// Shared types and constants for the Wishbone-to-64x512-SRAM bridge.
// Optional read buffer is enabled by defining WB_SRAM_RDBUF_EN.
package wb_sram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      ACK  = 2'd2
   } state_e;

   localparam int ROW_W        = 9;
   localparam int HALF_SEL_BIT = 2;
   localparam int WMASK_W      = 8;

   // A 32-bit bus word lands in the low or high half of a 64-bit row.
   function automatic logic [WMASK_W-1:0] half_mask(input logic h, input logic [3:0] sel);
      return h ? {sel, 4'b0000} : {4'b0000, sel};
   endfunction

endpackage

// File: rtl/wb_sram_bridge_64x512_if.sv
// Wishbone B4 classic slave-side signal bundle for the SRAM bridge.
// A transfer is requested while cyc & stb are high and completes on the single-cycle ack.
interface wb_sram_bridge_64x512_if #(
   parameter int WB_AW = 12
);

   logic             wbs_cyc_i;
   logic             wbs_stb_i;
   logic             wbs_we_i;
   logic [3:0]       wbs_sel_i;
   logic [WB_AW-1:0] wbs_adr_i;
   logic [31:0]      wbs_dat_i;
   logic             wbs_ack_o;
   logic [31:0]      wbs_dat_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

endinterface

// File: rtl/wb_sram_bridge_64x512_rdbuf.sv
// One-entry read buffer {valid, row, data}: hit compare, byte merge on write, fill on read.
// Instantiated only when WB_SRAM_RDBUF_EN is defined.
module wb_sram_rdbuf
   import wb_sram_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [ROW_W-1:0]   lookup_row_i,
   output logic               hit_o,
   output logic [63:0]        data_o,
   input  logic               fill_en_i,
   input  logic [ROW_W-1:0]   fill_row_i,
   input  logic [63:0]        fill_data_i,
   input  logic               wr_en_i,
   input  logic [ROW_W-1:0]   wr_row_i,
   input  logic [WMASK_W-1:0] wr_mask_i,
   input  logic [63:0]        wr_data_i
);

   logic             valid_q, valid_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [63:0]      data_q, data_d;

   assign hit_o  = valid_q && (row_q == lookup_row_i);
   assign data_o = data_q;

   always_comb begin
      valid_d = valid_q;
      row_d   = row_q;
      data_d  = data_q;
      if (fill_en_i) begin
         valid_d = 1'b1;
         row_d   = fill_row_i;
         data_d  = fill_data_i;
      end else if (wr_en_i && valid_q && (wr_row_i == row_q)) begin
         // Keep the buffer coherent with the macro row it shadows.
         for (int b = 0; b < WMASK_W; b++) begin
            if (wr_mask_i[b]) data_d[8*b +: 8] = wr_data_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         row_q   <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         row_q   <= row_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/wb_sram_bridge_64x512.sv
// Wishbone B4 classic 32-bit slave in front of a 64x512 1RW SRAM macro.
// Define WB_SRAM_RDBUF_EN to add a one-entry read buffer that short-circuits repeat row reads.
module wb_sram_bridge_64x512
   import wb_sram_pkg::*;
#(
   parameter int SRAM_AW = 10,
   parameter int SRAM_DW = 65,
   parameter int WB_AW   = 12
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_ni,
   wb_sram_bridge_64x512_if.slave wbs,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [WMASK_W-1:0]    sram_wmask0,
   output logic                  sram_spare_wen0,
   output logic [SRAM_AW-1:0]    sram_addr0,
   output logic [SRAM_DW-1:0]    sram_din0,
   input  logic [SRAM_DW-1:0]    sram_dout0,
   output state_e                dbg_state_o
);

   state_e           state_q, state_d;
   logic [63:0]      rd_q, rd_d;
   logic             h_q, h_d;
   logic [ROW_W-1:0] row_q, row_d;

   logic             req;
   logic             bus_h;
   logic [ROW_W-1:0] bus_row;
   logic             buf_hit;
   logic [63:0]      buf_data;
   logic             fill_en;
   logic             wr_en;

   assign bus_h   = wbs.wbs_adr_i[HALF_SEL_BIT];
   assign bus_row = wbs.wbs_adr_i[WB_AW-1:HALF_SEL_BIT+1];
   assign req     = wbs.wbs_cyc_i && wbs.wbs_stb_i && (state_q != ACK);

   assign sram_wmask0     = half_mask(bus_h, wbs.wbs_sel_i);
   assign sram_addr0      = {{(SRAM_AW-ROW_W){1'b0}}, bus_row};
   assign sram_din0       = {{(SRAM_DW-64){1'b0}}, wbs.wbs_dat_i, wbs.wbs_dat_i};
   assign sram_spare_wen0 = 1'b0;

   assign wbs.wbs_ack_o = (state_q == ACK);
   assign wbs.wbs_dat_o = (state_q == ACK) ? (h_q ? rd_q[63:32] : rd_q[31:0]) : 32'h0;
   assign dbg_state_o   = state_q;

`ifdef WB_SRAM_RDBUF_EN
   wb_sram_rdbuf u_rdbuf (
      .clk_i        (wb_clk_i),
      .rst_ni       (wb_rst_ni),
      .lookup_row_i (bus_row),
      .hit_o        (buf_hit),
      .data_o       (buf_data),
      .fill_en_i    (fill_en),
      .fill_row_i   (row_q),
      .fill_data_i  (sram_dout0[63:0]),
      .wr_en_i      (wr_en),
      .wr_row_i     (bus_row),
      .wr_mask_i    (sram_wmask0),
      .wr_data_i    ({wbs.wbs_dat_i, wbs.wbs_dat_i})
   );
`else
   assign buf_hit  = 1'b0;
   assign buf_data = 64'h0;
   logic rdbuf_unused;
   assign rdbuf_unused = ^{fill_en, wr_en};
`endif

   logic port_unused;
   assign port_unused = ^{sram_dout0[SRAM_DW-1:64], wbs.wbs_adr_i[1:0]};

   // Macro controls are only live while idle; the macro samples them on the next posedge.
   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      h_d       = h_q;
      row_d     = row_q;
      sram_csb0 = 1'b1;
      sram_web0 = 1'b1;
      fill_en   = 1'b0;
      wr_en     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               h_d   = bus_h;
               row_d = bus_row;
               if (wbs.wbs_we_i) begin
                  sram_csb0 = 1'b0;
                  sram_web0 = 1'b0;
                  wr_en     = 1'b1;
                  state_d   = ACK;
               end else if (buf_hit) begin
                  rd_d    = buf_data;
                  state_d = ACK;
               end else begin
                  sram_csb0 = 1'b0;
                  state_d   = RD;
               end
            end
         end
         RD: begin
            // dout0 is valid only until shortly after this closing edge.
            if (!wbs.wbs_cyc_i) begin
               state_d = IDLE;
            end else begin
               rd_d    = sram_dout0[63:0];
               fill_en = 1'b1;
               state_d = ACK;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         rd_q    <= '0;
         h_q     <= 1'b0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         h_q     <= h_d;
         row_q   <= row_d;
      end
   end

endmodule

// File: tb/tb_wb_sram_bridge_64x512.sv
// Bench for wb_sram_bridge_64x512 with a behavioural 64x512 macro (DELAY=3, T_HOLD=1).
// Table of directed accesses, hand sequences for abort/reset, then random traffic vs a reference.
module tb_wb_sram_bridge_64x512;
   import wb_sram_pkg::*;

`ifdef WB_SRAM_RDBUF_EN
   localparam bit BUF_EN = 1'b1;
`else
   localparam bit BUF_EN = 1'b0;
`endif

   localparam logic [64:0] POISON = 65'h1_5A5A_C3C3_5A5A_C3C3;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   wb_sram_bridge_64x512_if #(.WB_AW(12)) bus ();

   logic        csb, web, spare_wen;
   logic [7:0]  wmask;
   logic [9:0]  addr0;
   logic [64:0] din0;
   logic [64:0] dout0;
   state_e      dbg_state;

   wb_sram_bridge_64x512 dut (
      .wb_clk_i        (clk),
      .wb_rst_ni       (rst_n),
      .wbs             (bus),
      .sram_csb0       (csb),
      .sram_web0       (web),
      .sram_wmask0     (wmask),
      .sram_spare_wen0 (spare_wen),
      .sram_addr0      (addr0),
      .sram_din0       (din0),
      .sram_dout0      (dout0),
      .dbg_state_o     (dbg_state)
   );

   // ---------------- behavioural macro ----------------
   logic [63:0] mac_mem [512];
   int          mac_acc;
   logic        rd_pend, rd_live;
   logic [8:0]  rd_addr;

   initial begin
      for (int i = 0; i < 512; i++) mac_mem[i] = 64'h0;
      mac_acc = 0;
      rd_pend = 1'b0;
      rd_live = 1'b0;
      rd_addr = 9'h0;
      dout0   = POISON;
   end

   always @(posedge clk) begin
      if (!csb) begin
         mac_acc++;
         if (!web) begin
            for (int b = 0; b < 8; b++)
               if (wmask[b]) mac_mem[addr0[8:0]][8*b +: 8] = din0[8*b +: 8];
         end else begin
            rd_pend = 1'b1;
            rd_addr = addr0[8:0];
         end
      end
   end

   always @(negedge clk) begin
      if (rd_pend) begin
         rd_pend = 1'b0;
         #3;
         dout0   = {1'b0, mac_mem[rd_addr]};
         rd_live = 1'b1;
      end
   end

   always @(posedge clk) begin
      if (rd_live) begin
         #1;
         dout0   = POISON;
         rd_live = 1'b0;
      end
   end

   // ---------------- reference model ----------------
   logic [63:0] ref_mem [512];
   logic        ref_buf_v;
   logic [8:0]  ref_buf_row;

   task automatic ref_apply(input logic we, input logic [11:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, output logic [31:0] exp_dat, output int exp_lat);
      int row;
      int base;
      row  = int'(adr[11:3]);
      base = adr[2] ? 32 : 0;
      exp_dat = 32'h0;
      if (we) begin
         for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[row][base + 8*b +: 8] = dat[8*b +: 8];
         exp_lat = 1;
      end else begin
         exp_dat = ref_mem[row][base +: 32];
         exp_lat = (BUF_EN && ref_buf_v && (int'(ref_buf_row) == row)) ? 1 : 2;
         ref_buf_v   = 1'b1;
         ref_buf_row = adr[11:3];
      end
   endtask

   // ---------------- scoreboard ----------------
   int vectors;
   int miscompares;

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic bus_idle();
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = 12'h0;
      bus.wbs_dat_i = 32'h0;
   endtask

   task automatic run_op(input string name, input logic we, input logic [11:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat,
                         input logic [31:0] exp_dat, input int exp_lat);
      logic        csb_s, web_s, got, ack_next;
      logic [9:0]  addr_s;
      logic [7:0]  mask_s, exp_mask;
      logic [64:0] din_s;
      logic [31:0] rd;
      int          lat;
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_sel_i = sel;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = dat;
      #1;
      csb_s  = csb;
      web_s  = web;
      addr_s = addr0;
      mask_s = wmask;
      din_s  = din0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 8) begin
         @(negedge clk);
         lat++;
         if (bus.wbs_ack_o) got = 1'b1;
      end
      rd = bus.wbs_dat_o;
      bus_idle();
      @(negedge clk);
      ack_next = bus.wbs_ack_o;

      chk({name, " latency"}, 65'(lat), 65'(exp_lat));
      chk({name, " ack one cycle"}, 65'(ack_next), 65'd0);
      chk({name, " addr0"}, 65'(addr_s), {56'h0, adr[11:3]});
      chk({name, " csb0"}, 65'(csb_s), 65'((!we && exp_lat == 1) ? 1 : 0));
      chk({name, " web0"}, 65'(web_s), 65'(!we));
      if (we) begin
         exp_mask = adr[2] ? {sel, 4'h0} : {4'h0, sel};
         chk({name, " wmask0"}, 65'(mask_s), 65'(exp_mask));
         chk({name, " din0"}, din_s, {1'b0, dat, dat});
      end else begin
         chk({name, " rdata"}, 65'(rd), 65'(exp_dat));
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        we;
      logic [11:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic [31:0] exp_dat;
      int          lat_nobuf;
      int          lat_buf;
   } vec_t;

   vec_t tbl[18];

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] e_dat;
      int          e_lat;
      logic        we;
      logic [11:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      int          row;

      tbl[0]  = '{1'b1, 12'h004, 4'hF, 32'hDEADBEEF, 32'h0,        1, 1};
      tbl[1]  = '{1'b0, 12'h004, 4'hF, 32'h0,        32'hDEADBEEF, 2, 2};
      tbl[2]  = '{1'b0, 12'h000, 4'hF, 32'h0,        32'h0,        2, 1};
      tbl[3]  = '{1'b1, 12'h000, 4'hF, 32'h11223344, 32'h0,        1, 1};
      tbl[4]  = '{1'b1, 12'h000, 4'h2, 32'h0000AA00, 32'h0,        1, 1};
      tbl[5]  = '{1'b0, 12'h000, 4'hF, 32'h0,        32'h1122AA44, 2, 1};
      tbl[6]  = '{1'b1, 12'hFFC, 4'hF, 32'hCAFEF00D, 32'h0,        1, 1};
      tbl[7]  = '{1'b0, 12'h000, 4'hF, 32'h0,        32'h1122AA44, 2, 1};
      tbl[8]  = '{1'b0, 12'hFFC, 4'hF, 32'h0,        32'hCAFEF00D, 2, 2};
      tbl[9]  = '{1'b1, 12'h004, 4'h0, 32'h12345678, 32'h0,        1, 1};
      tbl[10] = '{1'b0, 12'h004, 4'hF, 32'h0,        32'hDEADBEEF, 2, 2};
      tbl[11] = '{1'b0, 12'h020, 4'hF, 32'h0,        32'h0,        2, 2};
      tbl[12] = '{1'b0, 12'h024, 4'hF, 32'h0,        32'h0,        2, 1};
      tbl[13] = '{1'b1, 12'h024, 4'hF, 32'hA5A5A5A5, 32'h0,        1, 1};
      tbl[14] = '{1'b0, 12'h024, 4'hF, 32'h0,        32'hA5A5A5A5, 2, 1};
      tbl[15] = '{1'b1, 12'h3F8, 4'hC, 32'h0BADC0DE, 32'h0,        1, 1};
      tbl[16] = '{1'b0, 12'h3F8, 4'hF, 32'h0,        32'h0BAD0000, 2, 2};
      tbl[17] = '{1'b0, 12'h3FC, 4'hF, 32'h0,        32'h0,        2, 1};

      vectors     = 0;
      miscompares = 0;
      for (int i = 0; i < 512; i++) ref_mem[i] = 64'h0;
      ref_buf_v   = 1'b0;
      ref_buf_row = 9'h0;

      // Reset: outputs quiet, macro untouched.
      bus_idle();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset ack", 65'(bus.wbs_ack_o), 65'd0);
      chk("reset dat_o", 65'(bus.wbs_dat_o), 65'd0);
      chk("reset csb0", 65'(csb), 65'd1);
      chk("reset state", 65'(dbg_state), 65'(IDLE));
      chk("reset spare_wen", 65'(spare_wen), 65'd0);
      chk("reset macro accesses", 65'(mac_acc), 65'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table.
      for (int i = 0; i < 18; i++) begin
         ref_apply(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, e_dat, e_lat);
         run_op($sformatf("tbl%0d", i), tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat,
                tbl[i].exp_dat, BUF_EN ? tbl[i].lat_buf : tbl[i].lat_nobuf);
      end

      // Abort: drop cyc while the read is outstanding; no ack may follow.
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'hF;
      bus.wbs_adr_i = 12'h010;
      @(negedge clk);
      chk("abort in RD", 65'(dbg_state), 65'(RD));
      bus_idle();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("abort no ack %0d", k), 65'(bus.wbs_ack_o), 65'd0);
      end
      ref_apply(1'b0, 12'h010, 4'hF, 32'h0, e_dat, e_lat);
      run_op("after abort", 1'b0, 12'h010, 4'hF, 32'h0, e_dat, e_lat);

      // Async reset while a read is outstanding.
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_adr_i = 12'h008;
      bus.wbs_sel_i = 4'hF;
      @(negedge clk);
      bus_idle();
      rst_n = 1'b0;
      #1;
      chk("midreset state", 65'(dbg_state), 65'(IDLE));
      chk("midreset ack", 65'(bus.wbs_ack_o), 65'd0);
      chk("midreset csb0", 65'(csb), 65'd1);
      @(negedge clk);
      rst_n = 1'b1;
      ref_buf_v = 1'b0;
      ref_apply(1'b0, 12'h000, 4'hF, 32'h0, e_dat, e_lat);
      run_op("after midreset", 1'b0, 12'h000, 4'hF, 32'h0, e_dat, e_lat);

      // Random traffic, rows biased toward a small set so the buffer sees hits.
      for (int n = 0; n < 200; n++) begin
         we  = 1'($urandom_range(0, 1));
         row = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 511));
         adr = {row[8:0], 1'($urandom_range(0, 1)), 2'b00};
         sel = 4'($urandom_range(0, 15));
         dat = $urandom;
         ref_apply(we, adr, sel, dat, e_dat, e_lat);
         run_op($sformatf("rnd%0d", n), we, adr, sel, dat, e_dat, e_lat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
